// File: rtl/alu_seq.sv
// Nibble-serial ALU sequencer: steps one 8-bit arithmetic request through operand
// loads and low/high nibble passes, then reports Z/N/H/C with a one-cycle done pulse.
module alu_seq (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic       req_cin,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       ctl_bus_sel,
  output logic [1:0] ctl_la,
  output logic [1:0] ctl_lb,
  output logic       ctl_ne,
  output logic       ctl_ci,
  output logic       ctl_l,
  output logic       ctl_h,
  output logic [1:0] ctl_oe,
  output logic       done,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       flag_c
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LDA  = 3'd1;
  localparam logic [2:0] ST_LDB  = 3'd2;
  localparam logic [2:0] ST_LO   = 3'd3;
  localparam logic [2:0] ST_HI   = 3'd4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADC  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SBC  = 3'd3;
  localparam logic [2:0] OP_NEG  = 3'd4;
  localparam logic [2:0] OP_CP   = 3'd5;

  localparam logic [1:0] LD_NO   = 2'd0;
  localparam logic [1:0] LD_BUS  = 2'd1;
  localparam logic [1:0] LD_ZERO = 2'd2;

  localparam logic [1:0] OE_NONE = 2'd0;
  localparam logic [1:0] OE_SH   = 2'd1;
  localparam logic [1:0] OE_RES  = 2'd2;

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [2:0] r_op;
  logic       r_cin;
  logic       r_hc;
  logic       r_done;
  logic       r_flag_z;
  logic       r_flag_n;
  logic       r_flag_h;
  logic       r_flag_c;
  logic       w_accept;
  logic       w_reserved;
  logic       w_sub;

  function automatic logic f_is_sub(input logic [2:0] op);
    logic s;
    s = (op == OP_SUB) || (op == OP_SBC) || (op == OP_NEG) || (op == OP_CP);
    return s;
  endfunction

  // Carry-in of the low pass; subtraction is A + ~B + 1, borrow-in inverts cin.
  function automatic logic f_lo_cin(input logic [2:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_ADC:  c = cin;
      OP_SBC:  c = ~cin;
      default: c = 1'b1;
    endcase
    return c;
  endfunction

  assign req_ready  = (r_state == ST_IDLE);
  assign w_accept   = req_valid && req_ready;
  assign w_reserved = (req_op[2:1] == 2'b11);
  assign w_sub      = f_is_sub(r_op);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_reserved)
          w_state_nxt = (req_op == OP_NEG) ? ST_LDB : ST_LDA;
      end
      ST_LDA:  w_state_nxt = ST_LDB;
      ST_LDB:  w_state_nxt = ST_LO;
      ST_LO:   w_state_nxt = ST_HI;
      ST_HI:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_cin   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= req_op;
        r_cin <= req_cin;
      end
    end
  end

  // Half-carry from the low pass feeds the high pass carry-in and the H flag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      r_hc <= 1'b0;
    else if (r_state == ST_LO)
      r_hc <= alu_carry;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_done   <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_h <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      r_done <= (r_state == ST_HI) || (w_accept && w_reserved);
      if (r_state == ST_HI) begin
        r_flag_z <= alu_zero;
        r_flag_n <= w_sub;
        r_flag_h <= r_hc ^ w_sub;
        r_flag_c <= alu_carry ^ w_sub;
      end
    end
  end

  assign done   = r_done;
  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
  assign flag_h = r_flag_h;
  assign flag_c = r_flag_c;

  // Control word is decoded from state alone so reset blanks it without a clock.
  always_comb begin
    ctl_bus_sel = 1'b0;
    ctl_la      = LD_NO;
    ctl_lb      = LD_NO;
    ctl_ne      = 1'b0;
    ctl_ci      = 1'b0;
    ctl_l       = 1'b0;
    ctl_h       = 1'b0;
    ctl_oe      = OE_NONE;
    case (r_state)
      ST_LDA: begin
        ctl_la      = LD_BUS;
        ctl_bus_sel = 1'b0;
      end
      ST_LDB: begin
        ctl_lb      = LD_BUS;
        ctl_bus_sel = 1'b1;
        ctl_oe      = OE_SH;
      end
      ST_LO: begin
        ctl_l  = 1'b1;
        ctl_ne = w_sub;
        ctl_la = (r_op == OP_NEG) ? LD_ZERO : LD_NO;
        ctl_ci = f_lo_cin(r_op, r_cin);
      end
      ST_HI: begin
        ctl_h  = 1'b1;
        ctl_ne = w_sub;
        ctl_ci = r_hc;
        ctl_oe = (r_op == OP_CP) ? OE_NONE : OE_RES;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver issues requests and queues the expected
// control words and results; a monitor plays the ALU and checks every cycle.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic       req_cin = 1'b0;
  logic       alu_carry = 1'b0;
  logic       alu_zero = 1'b0;
  logic       req_ready;
  logic       ctl_bus_sel;
  logic [1:0] ctl_la;
  logic [1:0] ctl_lb;
  logic       ctl_ne;
  logic       ctl_ci;
  logic       ctl_l;
  logic       ctl_h;
  logic [1:0] ctl_oe;
  logic       done;
  logic       flag_z;
  logic       flag_n;
  logic       flag_h;
  logic       flag_c;

  alu_seq dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_cin(req_cin),
    .alu_carry(alu_carry), .alu_zero(alu_zero),
    .ctl_bus_sel(ctl_bus_sel), .ctl_la(ctl_la), .ctl_lb(ctl_lb), .ctl_ne(ctl_ne),
    .ctl_ci(ctl_ci), .ctl_l(ctl_l), .ctl_h(ctl_h), .ctl_oe(ctl_oe),
    .done(done), .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] flags;   // {Z,N,H,C}
  } exp_t;

  // Control word layout: {bus_sel, la[1:0], lb[1:0], ne, ci, l, h, oe[1:0]}
  logic [10:0] q_ctl[$];
  exp_t        q_res[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [3:0]  mflags = 4'd0;
  logic [3:0]  last_flags = 4'd0;
  logic        cur_clo = 1'b0;
  logic        cur_chi = 1'b0;
  logic        cur_z = 1'b0;
  logic [10:0] m_w;
  exp_t        m_e;

  wire [10:0] ctl_word  = {ctl_bus_sel, ctl_la, ctl_lb, ctl_ne, ctl_ci, ctl_l, ctl_h, ctl_oe};
  wire [3:0]  dut_flags = {flag_z, flag_n, flag_h, flag_c};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  function automatic logic [10:0] cw(input logic bs, input logic [1:0] la, input logic [1:0] lb,
                                     input logic ne, input logic ci, input logic l,
                                     input logic h, input logic [1:0] oe);
    return {bs, la, lb, ne, ci, l, h, oe};
  endfunction

  // Reference: nibble-wise A + (sub ? ~B : B) + cin, as the ALU computes it.
  task automatic model_push(input logic [2:0] op, input logic cin,
                            input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic       sub, ci0, clo, chi;
    logic [7:0] aa, bb;
    logic [4:0] lo, hi;
    if (op[2:1] == 2'b11) begin
      e.cyc   = cyc + 1;
      e.flags = mflags;
      q_res.push_back(e);
      return;
    end
    sub = (op >= 3'd2);
    aa  = (op == 3'd4) ? 8'h00 : a;
    bb  = sub ? ~b : b;
    case (op)
      3'd0:    ci0 = 1'b0;
      3'd1:    ci0 = cin;
      3'd3:    ci0 = ~cin;
      default: ci0 = 1'b1;
    endcase
    lo  = {1'b0, aa[3:0]} + {1'b0, bb[3:0]} + {4'b0, ci0};
    clo = lo[4];
    hi  = {1'b0, aa[7:4]} + {1'b0, bb[7:4]} + {4'b0, clo};
    chi = hi[4];
    cur_clo = clo;
    cur_chi = chi;
    cur_z   = ({hi[3:0], lo[3:0]} == 8'h00);
    if (op != 3'd4) q_ctl.push_back(cw(1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    q_ctl.push_back(cw(1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
    q_ctl.push_back(cw(1'b0, (op == 3'd4) ? 2'd2 : 2'd0, 2'd0, sub, ci0, 1'b1, 1'b0, 2'd0));
    q_ctl.push_back(cw(1'b0, 2'd0, 2'd0, sub, clo, 1'b0, 1'b1, (op == 3'd5) ? 2'd0 : 2'd2));
    mflags  = {cur_z, sub, clo ^ sub, chi ^ sub};
    e.cyc   = cyc + ((op == 3'd4) ? 4 : 5);
    e.flags = mflags;
    q_res.push_back(e);
  endtask

  // Called shortly after a falling edge; returns the cycle stamp of the accept.
  task automatic issue(input logic [2:0] op, input logic cin, input logic [7:0] a,
                       input logic [7:0] b, input bit hold, output int acc);
    int waited;
    waited    = 0;
    acc       = -1;
    req_valid = 1'b1;
    req_op    = op;
    req_cin   = cin;
    while (!req_ready && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    model_push(op, cin, a, b);
    @(negedge clk); #1;
    req_op  = 3'($urandom);
    req_cin = 1'($urandom);
    if (!hold) req_valid = 1'b0;
  endtask

  // Monitor: checks every cycle and plays the ALU from the expected pass.
  always @(negedge clk) begin
    if (!nreset) begin
      chk("rst_ctl", 32'(ctl_word), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_flags", 32'(dut_flags), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
    end else begin
      chk("ready", 32'(req_ready), 32'(q_ctl.size() == 0));
      if (q_ctl.size() > 0) begin
        m_w = q_ctl.pop_front();
        chk("ctl_word", 32'(ctl_word), 32'(m_w));
      end else begin
        m_w = '0;
        chk("ctl_idle", 32'(ctl_word), 32'd0);
      end
      if (done) begin
        if (q_res.size() == 0) begin
          fail_now("done_spurious");
        end else begin
          m_e = q_res.pop_front();
          chk("done_cycle", 32'(cyc), 32'(m_e.cyc));
          chk("flags", 32'(dut_flags), 32'(m_e.flags));
          last_flags = m_e.flags;
        end
      end else begin
        chk("flags_hold", 32'(dut_flags), 32'(last_flags));
      end
    end
    if (m_w[3]) begin
      alu_carry = cur_clo;
      alu_zero  = 1'($urandom);
    end else if (m_w[2]) begin
      alu_carry = cur_chi;
      alu_zero  = cur_z;
    end else begin
      alu_carry = 1'($urandom);
      alu_zero  = 1'($urandom);
    end
  end

  initial begin
    int  c1, c2, waited;
    bit  hold;
    logic [2:0] op;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_ctl", 32'(ctl_word), 32'd0);
    nreset = 1'b1;
    @(negedge clk); #1;

    // Directed cases: NEG of 1, ADD 0x0F+0x01, SBC cin=1, CP equal operands.
    issue(3'd4, 1'($urandom), 8'h00, 8'h01, 1'b0, c1);
    repeat (6) begin @(negedge clk); #1; end
    issue(3'd0, 1'b0, 8'h0F, 8'h01, 1'b0, c1);
    issue(3'd3, 1'b1, 8'h3A, 8'h1C, 1'b0, c1);
    issue(3'd5, 1'b0, 8'h55, 8'h55, 1'b0, c1);

    // Back-to-back ADD then NEG with valid held high.
    issue(3'd0, 1'b1, 8'h12, 8'h34, 1'b1, c1);
    issue(3'd4, 1'b0, 8'h00, 8'h80, 1'b0, c2);
    chk("b2b_accept", 32'(c2), 32'(c1 + 5));

    // Reserved ops.
    issue(3'd6, 1'b1, 8'h00, 8'h00, 1'b0, c1);
    issue(3'd7, 1'b0, 8'h00, 8'h00, 1'b1, c1);
    issue(3'd1, 1'b1, 8'hFF, 8'h00, 1'b0, c1);

    // Reset in the high pass.
    issue(3'd2, 1'b0, 8'h10, 8'h20, 1'b0, c1);
    waited = 0;
    while (!ctl_h && waited < 20) begin @(negedge clk); #1; waited++; end
    if (!ctl_h) fail_now("hi_pass_timeout");
    nreset = 1'b0;
    #1;
    chk("rst_mid_ctl", 32'(ctl_word), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_flags", 32'(dut_flags), 32'd0);
    q_ctl.delete();
    q_res.delete();
    mflags     = 4'd0;
    last_flags = 4'd0;
    repeat (2) begin @(negedge clk); #1; end
    nreset = 1'b1;
    @(negedge clk); #1;
    issue(3'd0, 1'b0, 8'hA5, 8'h5B, 1'b0, c1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom);
      if (op > 3'd5 && $urandom_range(0, 9) < 7) op = 3'($urandom_range(0, 5));
      hold = (i != 299) && ($urandom_range(0, 2) == 0);
      issue(op, 1'($urandom), 8'($urandom), 8'($urandom), hold, c1);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
      end
    end

    repeat (10) begin @(negedge clk); #1; end
    chk("ctl_queue_drained", 32'(q_ctl.size()), 32'd0);
    chk("result_queue_drained", 32'(q_res.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Nibble-serial ALU sequencer for the CPU core. Accepts one 8-bit arithmetic request (ADD, ADC, SUB, SBC, NEG, CP) over a valid/ready handshake and drives the per-cycle ALU control word: operand loads, low-nibble pass, high-nibble pass. It latches the half-carry between passes and returns Z/N/H/C flags with a one-cycle done pulse. It is the issuing end of the ALU control-line interface. It holds no operand data; data moves on the ALU bus under `ctl_bus_sel`.

## Interface

Parameters: none.

- `clk` in 1: core clock, rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 3: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 NEG, 5 CP, 6/7 reserved.
- `req_cin` in 1: current C flag, sampled at accept.
- `alu_carry` in 1: ALU nibble carry-out of the current pass.
- `alu_zero` in 1: ALU 8-bit result-zero.
- `ctl_bus_sel` out 1: 0 = bus carries operand A, 1 = operand B.
- `ctl_la`, `ctl_lb` out 2 each: 0 NO_LD, 1 BUS_LD, 2 ZERO_LD.
- `ctl_ne` out 1: negate B (subtract).
- `ctl_ci` out 1: carry-in of the current pass.
- `ctl_l`, `ctl_h` out 1 each: low/high nibble pass.
- `ctl_oe` out 2: 0 NONE, 1 SH_OE, 2 RES_OE.
- `done` out 1: one-cycle completion pulse.
- `flag_z`, `flag_n`, `flag_h`, `flag_c` out 1 each: result flags, held until the next completion.

## Operation

- States: IDLE, LDA, LDB, LO, HI. Control outputs are a combinational function of the state and the latched op. In IDLE all control outputs are 0.
- Accept: `req_valid && req_ready` at a clock edge latches op and `req_cin`.
  - NEG goes to LDB.
  - ops 0–3 and 5 go to LDA.
  - reserved ops stay in IDLE, pulse `done` the next cycle, and leave the flags unchanged.
- LDA: `ctl_la`=BUS_LD, `ctl_bus_sel`=0. Next state LDB.
- LDB: `ctl_lb`=BUS_LD, `ctl_bus_sel`=1, `ctl_oe`=SH_OE. Next state LO.
- LO: `ctl_l`=1, `ctl_ne`=sub.
  - `ctl_la`=ZERO_LD for NEG, else NO_LD.
  - `ctl_ci`: ADD 0, ADC cin, SUB/CP/NEG 1, SBC !cin.
  - `alu_carry` is captured into `hc` at the end of the cycle.
  - Next state HI.
- HI: `ctl_h`=1, `ctl_ne`=sub, `ctl_ci`=`hc`.
  - `ctl_oe`=RES_OE, except NONE for CP.
  - At the end of the cycle, register the flags and `done`.
  - Next state IDLE.
- sub = op ∈ {SUB, SBC, NEG, CP}.
- Flags:
  - Z = `alu_zero` sampled in HI.
  - N = sub.
  - H = `hc` XOR sub.
  - C = `alu_carry` (sampled in HI) XOR sub.
- `req_ready` is high in IDLE, including the `done` cycle. This allows back-to-back requests.

## Timing

- Reset values: state IDLE, `hc`=0, `done`=0, all flags 0, all control outputs 0, `req_ready`=1.
- Latency from the accept edge to `done` high: 5 cycles for ADD/ADC/SUB/SBC/CP, 4 for NEG, 1 for reserved ops.
- Throughput: one op per 5 cycles (4 for NEG) with `req_valid` held high.
- `done` is high exactly one cycle. Flags change only on the edge that raises `done`.
- `req_op` and `req_cin` are don't-care after accept; later changes do not affect the running op.
- `alu_carry`/`alu_zero` are sampled only at the end of LO/HI. Values in other states are ignored.
- Reset asserted mid-op: immediate return to IDLE, control outputs 0 without waiting for a clock edge, no `done`, flags cleared.

## Test plan

- NEG, cin=x. Bench ALU carries LO=0, HI=0, zero=0 (b=0x01). Required:
  - cycle sequence LDB, LO (la=ZERO_LD, ci=1, ne=1), HI (ci=0, oe=RES_OE);
  - `done` 4 cycles after accept;
  - Z=0, N=1, H=1, C=1.
- ADD 0x0F+0x01 (LO carry 1, HI carry 0, zero 0). Required:
  - LDA, LDB, LO ci=0, HI ci=1;
  - `done` at 5 cycles;
  - Z=0, N=0, H=1, C=0.
- SBC with cin=1 and CP with cin=0. Required:
  - SBC: LO `ctl_ci`=0.
  - CP: LO `ctl_ci`=1 and `ctl_oe`=NONE in HI.
  - CP with carries 1/1 and zero=1: Z=1, N=1, H=0, C=0.
- Back-to-back ADD then NEG with `req_valid` held high: the second accept happens in the first op's `done` cycle; `done` pulses 5 cycles apart, then 4.
- Reserved op 6: `done` the next cycle, flags unchanged, control outputs stay 0.
- `nreset` low during HI:
  - control outputs 0 immediately, no `done`, flags 0;
  - after release, an ADD completes normally.
